// File: rtl/ffram_wb_pkg.sv
// Shared types and helpers for the banked flip-flop RAM Wishbone slave.
package ffram_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TERM = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Number of address bits that select a bank; zero for a single bank.
    function automatic int calcBankBits(input int numBanks);
        int bits;
        bits = 0;
        for (int i = 0; i < 4; i++) begin
            if ((1 << bits) < numBanks) begin
                bits = bits + 1;
            end
        end
        return bits;
    endfunction

    // Total number of 32-bit words across all banks.
    function automatic int calcTotalWords(input int numBanks, input int wordNum);
        return numBanks * wordNum;
    endfunction

    // Expands the four Wishbone byte enables into a 32-bit bit mask.
    function automatic logic [31:0] expandSel(input logic [3:0] sel);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{sel[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ffram_bank.sv
// One bank of WORD_NUM x 32 flip-flop storage with masked write and registered read.
module ffram_bank #(
    parameter int WORD_NUM = 64,
    parameter int AW       = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr_n,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_row,
    input  logic [31:0]   i_wdata,
    input  logic [31:0]   i_mask,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORD_NUM];
    logic [31:0] r_rdata;

    // Storage array: optional clear, otherwise masked bit-level write of one row.
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            for (int i = 0; i < WORD_NUM; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_row] <= (r_mem[i_row] & ~i_mask) | (i_wdata & i_mask);
        end
    end

    // Read register captures the addressed row when a read is requested.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_row];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ffram_wb_banked.sv
// Wishbone classic slave in front of word-interleaved flip-flop RAM banks,
// with base-address decode, wait states, error termination and cycle abort.
module ffram_wb_banked
    import ffram_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          NUM_BANKS      = 4,
    parameter int          WORD_NUM       = 64,
    parameter int          WAIT_STATES    = 1,
    parameter int          CLEAR_ON_RESET = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_o
);

    localparam int          BW          = calcBankBits(NUM_BANKS);
    localparam int          BKW         = (BW > 0) ? BW : 1;
    localparam int          RW          = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
    localparam int          TOTAL_WORDS = calcTotalWords(NUM_BANKS, WORD_NUM);
    localparam logic [31:0] SPAN_BYTES  = 32'(4 * TOTAL_WORDS);
    localparam logic [2:0]  CNT_LOAD    = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t           r_state;
    state_t           w_nextState;
    logic             r_we;
    logic [3:0]       r_sel;
    logic [31:0]      r_dat;
    logic [BKW-1:0]   r_bank;
    logic [RW-1:0]    r_row;
    logic [2:0]       r_cnt;

    logic [31:0]      w_off;
    logic             w_hit;
    logic [29:0]      w_idx;
    logic [29:0]      w_rowFull;
    logic [BKW-1:0]   w_decBank;
    logic [RW-1:0]    w_decRow;
    logic             w_accept;
    logic             w_commit;
    logic             w_accWe;
    logic [31:0]      w_accDat;
    logic [31:0]      w_accMask;
    logic [BKW-1:0]   w_accBank;
    logic [RW-1:0]    w_accRow;
    logic             w_clrN;
    logic [31:0]      w_bankRd [NUM_BANKS];
    logic [31:0]      w_rdSel;
    logic             w_ack;
    logic             w_err;
    logic             w_busy;
    logic [31:0]      w_datOut;
    logic             w_unused;

    // Address decode: offset from base, range check, then bank/row split.
    assign w_off     = wbs_adr_i - BASE_ADDR;
    assign w_hit     = (w_off < SPAN_BYTES);
    assign w_idx     = w_off[31:2];
    assign w_rowFull = w_idx >> BW;
    assign w_decRow  = w_rowFull[RW-1:0];
    assign w_unused  = ^w_rowFull;

    if (BW > 0) begin : g_multiBank
        assign w_decBank = w_idx[BKW-1:0];
    end else begin : g_singleBank
        assign w_decBank = '0;
    end

    assign w_accept = (r_state == IDLE) && wbs_stb_i && wbs_cyc_i && !w_ack && !w_err;

    // With zero wait states the access happens on the accept edge, so the
    // bank sees the live bus values; otherwise it sees the latched request.
    assign w_accWe   = (r_state == IDLE) ? wbs_we_i  : r_we;
    assign w_accDat  = (r_state == IDLE) ? wbs_dat_i : r_dat;
    assign w_accMask = expandSel((r_state == IDLE) ? wbs_sel_i : r_sel);
    assign w_accBank = (r_state == IDLE) ? w_decBank : r_bank;
    assign w_accRow  = (r_state == IDLE) ? w_decRow  : r_row;

    assign w_commit = wb_rst_ni && (w_nextState == TERM);
    assign w_clrN   = (CLEAR_ON_RESET != 0) ? wb_rst_ni : 1'b1;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic w_bankHit;
        assign w_bankHit = (w_accBank == BKW'(g));
        ffram_bank #(
            .WORD_NUM (WORD_NUM),
            .AW       (RW)
        ) u_bank (
            .i_clk   (wb_clk_i),
            .i_rst_n (wb_rst_ni),
            .i_clr_n (w_clrN),
            .i_we    (w_commit & w_accWe & w_bankHit),
            .i_re    (w_commit & ~w_accWe & w_bankHit),
            .i_row   (w_accRow),
            .i_wdata (w_accDat),
            .i_mask  (w_accMask),
            .o_rdata (w_bankRd[g])
        );
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic: decode result, wait countdown and abort on cyc drop.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_hit) begin
                        w_nextState = ERR;
                    end else if (WAIT_STATES == 0) begin
                        w_nextState = TERM;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!wbs_cyc_i) begin
                    w_nextState = IDLE;
                end else if (r_cnt == 3'd0) begin
                    w_nextState = TERM;
                end
            end
            TERM:    w_nextState = IDLE;
            ERR:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // FSM outputs: terminations and read data are driven purely from state.
    always_comb begin
        w_ack    = (r_state == TERM);
        w_err    = (r_state == ERR);
        w_busy   = (r_state != IDLE);
        w_datOut = '0;
        if ((r_state == TERM) && !r_we) begin
            w_datOut = w_rdSel;
        end
    end

    // Pick the read register of the bank that served the current request.
    always_comb begin
        w_rdSel = '0;
        for (int g = 0; g < NUM_BANKS; g++) begin
            if (r_bank == BKW'(g)) begin
                w_rdSel = w_bankRd[g];
            end
        end
    end

    // Request latch and wait-state counter.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_we   <= 1'b0;
            r_sel  <= '0;
            r_dat  <= '0;
            r_bank <= '0;
            r_row  <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_we   <= wbs_we_i;
            r_sel  <= wbs_sel_i;
            r_dat  <= wbs_dat_i;
            r_bank <= w_decBank;
            r_row  <= w_decRow;
            r_cnt  <= CNT_LOAD;
        end else if ((r_state == WAIT) && (r_cnt != 3'd0)) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign wbs_ack_o = w_ack;
    assign wbs_err_o = w_err;
    assign wbs_dat_o = w_datOut;
    assign busy_o    = w_busy;

endmodule
